// File: rtl/shift595_chain_driver.sv
// shift595_chain_driver: multi-lane serial driver for daisy-chained 74LV595 banks with shared SRCLK/RCLK
module shift595_chain_driver #(
  parameter int CHANNELS   = 4,
  parameter int WIDTH      = 16,
  parameter int DIV        = 1,
  parameter int MSB_FIRST  = 1,
  parameter int CONTINUOUS = 1
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic [CHANNELS*WIDTH-1:0] data,
  input  logic                      start,
  output logic                      busy,
  output logic                      done,
  output logic                      SRCLK,
  output logic                      RCLK,
  output logic [CHANNELS-1:0]       SER,
  output logic                      OE_n
);
  localparam int DW = DIV > 1 ? $clog2(DIV) : 1;
  localparam int BW = $clog2(WIDTH);
  localparam int FB = MSB_FIRST != 0 ? WIDTH - 1 : 0;
  typedef enum logic [1:0] {IDLE, SHIFT, LATCH} state_t;
  state_t                    r_state, w_state;
  logic [DW-1:0]             r_div, w_div;
  logic [BW-1:0]             r_bit, w_bit;
  logic                      r_phase, w_phase, r_lat, w_lat, w_tick, w_fin;
  logic [CHANNELS*WIDTH-1:0] r_sh, w_sh;
  logic [CHANNELS-1:0]       w_ser, r_ser;
  logic                      r_busy, r_done, r_srclk, r_rclk, r_oe_n;
  // next-state: divider, bit sequencing, lane shifting and latch pulse
  always_comb begin
    w_tick  = r_div == DW'(DIV - 1);
    w_state = r_state;
    w_div   = r_div;
    w_bit   = r_bit;
    w_phase = r_phase;
    w_lat   = r_lat;
    w_sh    = r_sh;
    w_fin   = 1'b0;
    w_ser   = '0;
    case (r_state)
      IDLE: begin
        w_div = '0;
        if (CONTINUOUS != 0 || start) begin
          w_state = SHIFT;
          w_sh    = data;
          w_bit   = '0;
          w_phase = 1'b0;
          w_lat   = 1'b0;
        end
      end
      SHIFT: begin
        w_div = w_tick ? '0 : r_div + 1'b1;
        if (w_tick) begin
          w_phase = !r_phase;
          if (r_phase) begin
            for (int c = 0; c < CHANNELS; c++)
              w_sh[c*WIDTH +: WIDTH] = MSB_FIRST != 0 ? {r_sh[c*WIDTH +: WIDTH-1], 1'b0}
                                                      : {1'b0, r_sh[c*WIDTH+1 +: WIDTH-1]};
            w_bit = r_bit + 1'b1;
            if (r_bit == BW'(WIDTH - 1)) begin
              w_state = LATCH;
              w_lat   = 1'b0;
            end
          end
        end
      end
      LATCH: begin
        w_div = w_tick ? '0 : r_div + 1'b1;
        if (w_tick) begin
          w_lat = 1'b1;
          if (r_lat) begin
            w_state = IDLE;
            w_fin   = 1'b1;
          end
        end
      end
      default: w_state = IDLE;
    endcase
    for (int c = 0; c < CHANNELS; c++)
      w_ser[c] = w_state == SHIFT && w_sh[c*WIDTH + FB];
  end
  // state and registered outputs, decoded from the next state so pins change glitch-free on the edge
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state <= IDLE;
      r_div   <= '0;
      r_bit   <= '0;
      r_phase <= 1'b0;
      r_lat   <= 1'b0;
      r_sh    <= '0;
      r_ser   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_srclk <= 1'b0;
      r_rclk  <= 1'b0;
      r_oe_n  <= 1'b1;
    end else begin
      r_state <= w_state;
      r_div   <= w_div;
      r_bit   <= w_bit;
      r_phase <= w_phase;
      r_lat   <= w_lat;
      r_sh    <= w_sh;
      r_ser   <= w_ser;
      r_busy  <= w_state != IDLE;
      r_done  <= w_fin;
      r_srclk <= w_state == SHIFT && w_phase;
      r_rclk  <= w_state == LATCH && !w_lat;
      if (w_fin) r_oe_n <= 1'b0;
    end
  end
  assign busy  = r_busy;
  assign done  = r_done;
  assign SRCLK = r_srclk;
  assign RCLK  = r_rclk;
  assign SER   = r_ser;
  assign OE_n  = r_oe_n;
endmodule

// File: tb/tb_shift595_chain_driver.sv
// tb_shift595_chain_driver: four driver configurations decoded from their pins against a frame scoreboard
module tb_shift595_chain_driver;
  localparam int WV[4] = '{16, 8, 16, 16};
  localparam int DV[4] = '{1, 1, 3, 1};
  localparam int MV[4] = '{1, 0, 1, 1};
  localparam int TV[4] = '{1, 1, 1, 0};
  localparam int CV[4] = '{4, 2, 1, 1};
  logic clk = 1'b0;
  logic rn0, rn3, start3;
  logic [63:0] d0;
  logic [15:0] d1, d2, d3;
  logic [3:0] busy_v, done_v, srclk_v, rclk_v, oe_v, rn_v;
  logic [3:0] p_b = '0, p_s = '0, p_r = '0;
  logic [3:0] ser0;
  logic [1:0] ser1;
  logic [0:0] ser2, ser3;
  logic [3:0] ser_v [4];
  logic [15:0] acc [4][4];
  logic [63:0] sbq [4][$];
  int hi_b[4], lo_b[4], hi_s[4], lo_s[4], hi_r[4], rises[4], rc[4];
  bit seen[4];
  int n_assert = 0, n_fail = 0;
  always #5 clk = ~clk;
  assign rn_v = {rn3, rn0, rn0, rn0};
  assign ser_v[0] = ser0;
  assign ser_v[1] = {2'b0, ser1};
  assign ser_v[2] = {3'b0, ser2};
  assign ser_v[3] = {3'b0, ser3};
  shift595_chain_driver #(.CHANNELS(4), .WIDTH(16), .DIV(1), .MSB_FIRST(1), .CONTINUOUS(1)) u0 (
    .clk(clk), .resetn(rn0), .data(d0), .start(1'b0), .busy(busy_v[0]), .done(done_v[0]),
    .SRCLK(srclk_v[0]), .RCLK(rclk_v[0]), .SER(ser0), .OE_n(oe_v[0]));
  shift595_chain_driver #(.CHANNELS(2), .WIDTH(8), .DIV(1), .MSB_FIRST(0), .CONTINUOUS(1)) u1 (
    .clk(clk), .resetn(rn0), .data(d1), .start(1'b0), .busy(busy_v[1]), .done(done_v[1]),
    .SRCLK(srclk_v[1]), .RCLK(rclk_v[1]), .SER(ser1), .OE_n(oe_v[1]));
  shift595_chain_driver #(.CHANNELS(1), .WIDTH(16), .DIV(3), .MSB_FIRST(1), .CONTINUOUS(1)) u2 (
    .clk(clk), .resetn(rn0), .data(d2), .start(1'b0), .busy(busy_v[2]), .done(done_v[2]),
    .SRCLK(srclk_v[2]), .RCLK(rclk_v[2]), .SER(ser2), .OE_n(oe_v[2]));
  shift595_chain_driver #(.CHANNELS(1), .WIDTH(16), .DIV(1), .MSB_FIRST(1), .CONTINUOUS(0)) u3 (
    .clk(clk), .resetn(rn3), .data(d3), .start(start3), .busy(busy_v[3]), .done(done_v[3]),
    .SRCLK(srclk_v[3]), .RCLK(rclk_v[3]), .SER(ser3), .OE_n(oe_v[3]));

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_done3();
    int k = 0;
    while (!done_v[3] && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (!done_v[3]) chk("u3 done_timeout", 64'd0, 64'd1);
  endtask

  // pin-level monitor: decodes SER on SRCLK rises, checks frames on RCLK rises, measures phase widths
  always @(negedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (rn_v[i]) begin
        if (srclk_v[i] && !p_s[i]) begin
          if (rises[i] > 0) chk($sformatf("u%0d srclk_low", i), 64'(lo_s[i]), 64'(DV[i]));
          rises[i]++;
          lo_s[i] = 0;
          for (int c = 0; c < 4; c++)
            acc[i][c] = MV[i] != 0 ? {acc[i][c][14:0], ser_v[i][c]} : {ser_v[i][c], acc[i][c][15:1]};
        end
        if (!srclk_v[i] && p_s[i]) begin
          chk($sformatf("u%0d srclk_high", i), 64'(hi_s[i]), 64'(DV[i]));
          hi_s[i] = 0;
        end
        if (srclk_v[i]) hi_s[i]++; else lo_s[i]++;
        if (rclk_v[i] && !p_r[i]) begin
          logic [63:0] got;
          chk($sformatf("u%0d srclk_rises", i), 64'(rises[i]), 64'(WV[i]));
          rises[i] = 0;
          rc[i]++;
          hi_r[i] = 0;
          got = '0;
          for (int c = 0; c < CV[i]; c++)
            got[c*16 +: 16] = MV[i] != 0 ? acc[i][c] & 16'((32'd1 << WV[i]) - 1)
                                         : 16'(acc[i][c] >> (16 - WV[i]));
          if (sbq[i].size() > 0) chk($sformatf("u%0d frame", i), got, sbq[i].pop_front());
        end
        if (!rclk_v[i] && p_r[i]) chk($sformatf("u%0d rclk_high", i), 64'(hi_r[i]), 64'(DV[i]));
        if (rclk_v[i]) hi_r[i]++;
        if (busy_v[i] && !p_b[i]) begin
          if (seen[i] && TV[i] != 0) chk($sformatf("u%0d idle_gap", i), 64'(lo_b[i]), 64'd1);
          hi_b[i] = 0;
        end
        if (!busy_v[i] && p_b[i]) begin
          chk($sformatf("u%0d busy_len", i), 64'(hi_b[i]), 64'((2 * WV[i] + 2) * DV[i]));
          chk($sformatf("u%0d done_after_busy", i), 64'(done_v[i]), 64'd1);
          chk($sformatf("u%0d oe_after_frame", i), 64'(oe_v[i]), 64'd0);
          seen[i] = 1'b1;
          lo_b[i] = 0;
        end
        if (done_v[i]) chk($sformatf("u%0d done_placement", i), 64'(!busy_v[i] && p_b[i]), 64'd1);
        if (busy_v[i]) hi_b[i]++; else lo_b[i]++;
      end else begin
        rises[i] = 0; hi_s[i] = 0; lo_s[i] = 0; hi_r[i] = 0; hi_b[i] = 0; lo_b[i] = 0; seen[i] = 1'b0;
        for (int c = 0; c < 4; c++) acc[i][c] = '0;
      end
      p_s[i] = srclk_v[i];
      p_r[i] = rclk_v[i];
      p_b[i] = busy_v[i];
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit act, oe_low;
    int nd, rcb, k;
    rn0 = 1'b0; rn3 = 1'b0; start3 = 1'b0;
    d0 = {16'hFFFF, 16'h8000, 16'h0001, 16'hA5C3};
    d1 = {8'h80, 8'h01};
    d2 = 16'hC3A5;
    d3 = 16'h0000;
    repeat (3) @(negedge clk);
    chk("u0 rst busy", 64'(busy_v[0]), 64'd0);
    chk("u0 rst done", 64'(done_v[0]), 64'd0);
    chk("u0 rst srclk", 64'(srclk_v[0]), 64'd0);
    chk("u0 rst rclk", 64'(rclk_v[0]), 64'd0);
    chk("u0 rst ser", 64'(ser0), 64'd0);
    chk("u0 rst oe_n", 64'(oe_v[0]), 64'd1);
    chk("u3 rst oe_n", 64'(oe_v[3]), 64'd1);
    repeat (2) sbq[0].push_back(64'hFFFF_8000_0001_A5C3);
    repeat (2) sbq[1].push_back(64'h0000_0000_0080_0001);
    repeat (2) sbq[2].push_back(64'h0000_0000_0000_C3A5);
    rn0 = 1'b1; rn3 = 1'b1;
    act = 1'b0;
    repeat (40) begin
      @(negedge clk);
      act |= busy_v[3] | srclk_v[3] | rclk_v[3] | done_v[3];
    end
    chk("u3 idle_without_start", 64'(act), 64'd0);
    d3 = 16'h1234;
    sbq[3].push_back(64'h1234);
    start3 = 1'b1;
    @(negedge clk);
    start3 = 1'b0;
    chk("u3 busy_after_start", 64'(busy_v[3]), 64'd1);
    repeat (10) @(negedge clk);
    d3 = 16'hFFFF;
    sbq[3].push_back(64'hFFFF);
    wait_done3();
    start3 = 1'b1;
    @(negedge clk);
    start3 = 1'b0;
    chk("u3 start_in_done_cycle", 64'(busy_v[3]), 64'd1);
    wait_done3();
    d3 = 16'h5A5A;
    sbq[3].push_back(64'h5A5A);
    start3 = 1'b1;
    repeat (20) @(negedge clk);
    start3 = 1'b0;
    nd = 0;
    repeat (80) begin
      @(negedge clk);
      nd += int'(done_v[3]);
    end
    chk("u3 held_start_one_frame", 64'(nd), 64'd1);
    d3 = 16'hBEEF;
    start3 = 1'b1;
    @(negedge clk);
    start3 = 1'b0;
    rcb = rc[3];
    repeat (16) @(negedge clk);
    rn3 = 1'b0;
    @(negedge clk);
    chk("u3 midrst busy", 64'(busy_v[3]), 64'd0);
    chk("u3 midrst done", 64'(done_v[3]), 64'd0);
    chk("u3 midrst srclk", 64'(srclk_v[3]), 64'd0);
    chk("u3 midrst rclk", 64'(rclk_v[3]), 64'd0);
    chk("u3 midrst ser", 64'(ser3), 64'd0);
    chk("u3 midrst oe_n", 64'(oe_v[3]), 64'd1);
    @(negedge clk);
    rn3 = 1'b1;
    repeat (3) @(negedge clk);
    chk("u3 no_rclk_partial", 64'(rc[3]), 64'(rcb));
    d3 = 16'h0F0F;
    sbq[3].push_back(64'h0F0F);
    start3 = 1'b1;
    @(negedge clk);
    start3 = 1'b0;
    oe_low = 1'b0;
    k = 0;
    while (!done_v[3] && k < 200) begin
      oe_low |= !oe_v[3];
      @(negedge clk);
      k++;
    end
    chk("u3 oe_held_until_done", 64'(oe_low), 64'd0);
    chk("u3 oe_falls_with_done", 64'({done_v[3], oe_v[3]}), 64'd2);
    repeat (60) @(negedge clk);
    for (int i = 0; i < 4; i++) chk($sformatf("u%0d scoreboard_drained", i), 64'(sbq[i].size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
